// File: rtl/rom_boot_loader.sv
// Copies NUM_WORDS words from a combinational instruction ROM into memory, then releases the CPU reset.
// Optional readback check of every written word is enabled with the BOOT_VERIFY_EN macro.
module rom_boot_loader #(
  parameter logic [22:0] BASE_ADDR = 23'h000000,
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_instr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        err,
  output logic        cpu_rst_n
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
`ifdef BOOT_VERIFY_EN
    VERIFY,
`endif
    DONE,
    ERROR
  } state_e;

  localparam logic [6:0] LAST = 7'(NUM_WORDS - 1);

  state_e      state_q;
  logic [6:0]  cnt_q;
  logic [6:0]  cnt_d;
  logic [31:0] wdata_q;
  logic        req_q;
  logic        we_q;
  logic        done_q;
  logic        err_q;
  logic        cpu_rst_n_q;

  assign cnt_d     = cnt_q + 7'd1;
  assign rom_addr  = cnt_q[5:0];
  assign mem_addr  = BASE_ADDR + {16'd0, cnt_q};
  assign mem_wdata = wdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

`ifndef BOOT_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            cnt_q   <= '0;
          end
        end
        FETCH: begin
          wdata_q <= rom_instr;
          req_q   <= 1'b1;
          we_q    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          if (mem_ack) begin
`ifdef BOOT_VERIFY_EN
            // Readback reuses the held address; only the direction flips.
            we_q    <= 1'b0;
            state_q <= VERIFY;
`else
            req_q <= 1'b0;
            if (cnt_q == LAST) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_d;
              state_q <= FETCH;
            end
`endif
          end
        end
`ifdef BOOT_VERIFY_EN
        VERIFY: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (mem_rdata != wdata_q) begin
              state_q <= ERROR;
            end else if (cnt_q == LAST) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_d;
              state_q <= FETCH;
            end
          end
        end
`endif
        DONE: begin
          // done/cpu_rst_n follow one edge after entry into DONE.
          if (start) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= FETCH;
          end else begin
            done_q      <= 1'b1;
            cpu_rst_n_q <= 1'b1;
          end
        end
        ERROR: begin
          if (start) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= FETCH;
          end else begin
            err_q       <= 1'b1;
            cpu_rst_n_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rom_boot_loader.md
ROM_BOOT_LOADER -- requirements
Module: rom_boot_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 23'h000000: word address of the first memory write.
REQ-002 SHALL have parameter NUM_WORDS, default 64: number of ROM words copied, range 1..64.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin copy when sampled high in IDLE, DONE or ERROR.
REQ-006 SHALL have port rom_addr  output  6  word index into the combinational instruction ROM.
REQ-007 SHALL have port rom_instr  input  32  ROM data for rom_addr, valid in the same cycle.
REQ-008 SHALL have port mem_req  output  1  memory request; held until acknowledged.
REQ-009 SHALL have port mem_we  output  1  1 = write, 0 = read, valid while mem_req is high.
REQ-010 SHALL have port mem_addr  output  23  word-addressed memory address.
REQ-011 SHALL have port mem_wdata  output  32  write data.
REQ-012 SHALL have port mem_ack  input  1  request accepted or completed; read data is valid with it.
REQ-013 SHALL have port mem_rdata  input  32  read data, used only with BOOT_VERIFY_EN.
REQ-014 SHALL have port done  output  1  copy complete; high in DONE.
REQ-015 SHALL have port err  output  1  verify mismatch; high in ERROR.
REQ-016 SHALL have port cpu_rst_n  output  1  CPU reset; high only in DONE.

Function
REQ-017 SHALL use states IDLE, FETCH, WRITE, VERIFY (macro only), DONE and ERROR.
REQ-018 SHALL keep a 7-bit word counter cnt; rom_addr = cnt[5:0]; mem_addr = BASE_ADDR + cnt, modulo 2^23.
- Transitions:
  - IDLE + start -> FETCH with cnt = 0.
  - FETCH -> WRITE after one cycle; latch rom_instr into the mem_wdata register.
- Handshake:
  - REQ-019 In WRITE, mem_req SHALL be 1 and mem_we SHALL be 1.
  - mem_addr and mem_wdata SHALL stay stable until mem_ack is sampled high.
  - mem_req SHALL go low in the cycle after mem_ack is sampled high.
- REQ-020 When mem_ack is high in WRITE:
  - If cnt = NUM_WORDS-1, the next state SHALL be DONE.
  - Otherwise cnt SHALL increment and the next state SHALL be FETCH.
- REQ-021 With mem_ack held high, each word SHALL take exactly 2 cycles; done SHALL rise 2*NUM_WORDS+1 edges after the edge that samples start.
- REQ-022 mem_ack outside a request SHALL be ignored; start outside IDLE, DONE and ERROR SHALL be ignored.
- REQ-023 In DONE: done = 1 and cpu_rst_n = 1; the block SHALL stay in DONE until start or reset.
- REQ-024 In ERROR: err = 1 and cpu_rst_n = 0; the block SHALL stay in ERROR until start or reset.
- REQ-025 start in DONE or ERROR SHALL:
  - clear done and err;
  - drive cpu_rst_n low on the next edge;
  - begin a new copy at cnt = 0.
- REQ-026 cnt SHALL never exceed NUM_WORDS-1; rom_addr SHALL not wrap during a copy.

Reset
REQ-027 rst_n low at an edge SHALL force, on that edge, regardless of state or an outstanding request:
- state IDLE;
- cnt = 0;
- mem_req = 0, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0;
- done = 0, err = 0, cpu_rst_n = 0;
- rom_addr = 0.
REQ-028 A request abandoned by reset SHALL not be re-issued; the next copy SHALL start from cnt = 0.

Configuration
REQ-029 Macro BOOT_VERIFY_EN:
- When defined:
  - Acknowledged WRITE -> VERIFY.
  - VERIFY: mem_req = 1, mem_we = 0, same mem_addr.
  - On mem_ack: if mem_rdata equals mem_wdata, take the REQ-020 transition; otherwise go to ERROR.
- When undefined:
  - No VERIFY state; mem_we is always 1 during a request.
  - mem_rdata is unused; err stays 0.

Verification
REQ-030 Reset, start=1 for one cycle, mem_ack tied 1, ROM word 0 = 32'h24010001 -> first write: mem_addr = BASE_ADDR, mem_wdata = 32'h24010001.
REQ-031 NUM_WORDS = 36, ack tied 1 -> exactly 36 writes with addresses BASE_ADDR..BASE_ADDR+35; done and cpu_rst_n rise 73 edges after start.
REQ-032 mem_ack delayed 3 cycles on word 5 -> mem_req, mem_addr and mem_wdata held for 4 cycles; no duplicate or skipped write.
REQ-033 rst_n low for one edge during word 10 -> mem_req = 0 and cpu_rst_n = 0 next cycle, state IDLE; a later start rewrites from word 0.
REQ-034 BOOT_VERIFY_EN, memory model corrupts word 3 on readback -> err = 1, done = 0, cpu_rst_n = 0, no write to BASE_ADDR+4.
REQ-035 start pulsed in DONE -> cpu_rst_n low the next cycle and a full second copy completes identically.
